amo_unit: RTL and testbench

// - RV32A atomic sequencer: runs LR.W, SC.W and AMO*.W as read-modify-write transactions on the data-memory port.
// - Initiator/driver side of the reservation set: sets it on LR, checks and clears it on SC, clears it on a matching AMO.
// - Sits beside the LSU in MEM stage; the pipeline stalls while busy_o=1; returns rd writeback on done_o.

---
 rtl/amo_pkg.sv | 34 +++
 rtl/amo_if.sv | 51 +++++
 rtl/amo_alu.sv | 36 +++
 rtl/amo_unit.sv | 164 ++++++++++++++++
 tb/tb_amo_unit.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/amo_pkg.sv
// Opcode constants, FSM state type and small helpers for the RV32A atomic sequencer.
package amo_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } amo_state_t;

    function automatic logic f5_legal(input logic [4:0] f5);
        case (f5)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR,
            F5_AND, F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amo_if.sv
// Pipeline command, data-memory port and reservation-set port of the atomic sequencer.
// slave = the sequencer itself, master = pipeline/memory/reservation side.
interface amo_if;
    import amo_pkg::*;

    logic            start_i;
    logic [4:0]      funct5_i;
    logic [XLEN-1:0] addr_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;

    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            rd_we_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] result_o;

    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_ready_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    logic            rsv_set_o;
    logic            rsv_clr_o;
    logic [XLEN-1:0] rsv_addr_o;
    logic            rsv_valid_i;
    logic [XLEN-1:0] rsv_addr_i;

    modport slave (
        input  start_i, funct5_i, addr_i, rs2_i, rd_i,
        input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
        input  rsv_valid_i, rsv_addr_i,
        output busy_o, done_o, err_o, rd_we_o, rd_o, result_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output rsv_set_o, rsv_clr_o, rsv_addr_o
    );

    modport master (
        output start_i, funct5_i, addr_i, rs2_i, rd_i,
        output mem_ready_i, mem_rvalid_i, mem_rdata_i,
        output rsv_valid_i, rsv_addr_i,
        input  busy_o, done_o, err_o, rd_we_o, rd_o, result_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  rsv_set_o, rsv_clr_o, rsv_addr_o
    );

endinterface

// File: rtl/amo_alu.sv
// Purpose: computes the value an AMO writes back from the old memory word and rs2.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module amo_alu
    import amo_pkg::*;
(
    input  logic [4:0]      funct5,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] new_val
);

    logic s_lt;
    logic u_lt;

    // rs2 strictly less than old; equal operands therefore keep the old value.
    assign s_lt = $signed(rs2_val) < $signed(old_val);
    assign u_lt = rs2_val < old_val;

    always_comb begin
        new_val = old_val;
        case (funct5)
            F5_ADD:  new_val = old_val + rs2_val;
            F5_SWAP: new_val = rs2_val;
            F5_XOR:  new_val = old_val ^ rs2_val;
            F5_OR:   new_val = old_val | rs2_val;
            F5_AND:  new_val = old_val & rs2_val;
            F5_MIN:  new_val = s_lt ? rs2_val : old_val;
            F5_MAX:  new_val = (!s_lt && (rs2_val != old_val)) ? rs2_val : old_val;
            F5_MINU: new_val = u_lt ? rs2_val : old_val;
            F5_MAXU: new_val = (!u_lt && (rs2_val != old_val)) ? rs2_val : old_val;
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/amo_unit.sv
// Purpose: sequences LR.W / SC.W / AMO*.W as read-modify-write on the data port and drives the reservation set.
// Latency: best case LR 3, SC hit 2, AMO 4, SC miss / error 1 cycle from start to done.
// Backpressure: requests held stable until mem_ready_i; start_i ignored while busy (not queued).
module amo_unit
    import amo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    amo_if.slave  bus
);

    amo_state_t      state;
    logic [4:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic [XLEN-1:0] rsv_addr_q;
    logic            done_q;
    logic            err_q;
    logic            rd_we_q;
    logic            req_q;
    logic            we_q;
    logic            set_q;
    logic            clr_q;
    logic            clr_pend;

    logic            launch_hit;
    logic            launch_bad;
    logic [XLEN-1:0] alu_new;

    assign launch_hit = bus.rsv_valid_i && (bus.rsv_addr_i == bus.addr_i);
    assign launch_bad = (bus.addr_i[1:0] != 2'b00) || !f5_legal(bus.funct5_i);

    // ALU works on the read data as it arrives so the write can be issued next cycle.
    amo_alu u_alu (
        .funct5  (op_q),
        .old_val (bus.mem_rdata_i),
        .rs2_val (rs2_q),
        .new_val (alu_new)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs2_q       <= '0;
            old_q       <= '0;
            result_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsv_addr_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_we_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            set_q       <= 1'b0;
            clr_q       <= 1'b0;
            clr_pend    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_we_q <= 1'b0;
            set_q   <= 1'b0;
            clr_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op_q       <= bus.funct5_i;
                        rd_q       <= bus.rd_i;
                        rs2_q      <= bus.rs2_i;
                        mem_addr_q <= bus.addr_i;
                        clr_pend   <= launch_hit;
                        if (launch_bad) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else if (bus.funct5_i == F5_SC) begin
                            if (launch_hit) begin
                                state       <= S_WR_REQ;
                                req_q       <= 1'b1;
                                we_q        <= 1'b1;
                                mem_wdata_q <= bus.rs2_i;
                            end else begin
                                // Lost reservation: report failure without touching memory.
                                state    <= S_DONE;
                                done_q   <= 1'b1;
                                result_q <= XLEN'(1);
                                rd_we_q  <= (bus.rd_i != 5'd0);
                                clr_q    <= 1'b1;
                            end
                        end else begin
                            state <= S_RD_REQ;
                            req_q <= 1'b1;
                            we_q  <= 1'b0;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus.mem_ready_i) begin
                        req_q <= 1'b0;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.mem_rvalid_i) begin
                        old_q <= bus.mem_rdata_i;
                        if (op_q == F5_LR) begin
                            state      <= S_DONE;
                            done_q     <= 1'b1;
                            result_q   <= bus.mem_rdata_i;
                            rd_we_q    <= (rd_q != 5'd0);
                            set_q      <= 1'b1;
                            rsv_addr_q <= mem_addr_q;
                        end else begin
                            state       <= S_WR_REQ;
                            req_q       <= 1'b1;
                            we_q        <= 1'b1;
                            mem_wdata_q <= alu_new;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus.mem_ready_i) begin
                        req_q    <= 1'b0;
                        we_q     <= 1'b0;
                        state    <= S_DONE;
                        done_q   <= 1'b1;
                        rd_we_q  <= (rd_q != 5'd0);
                        clr_q    <= clr_pend;
                        result_q <= (op_q == F5_SC) ? '0 : old_q;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o      = (state != S_IDLE);
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.rd_we_o     = rd_we_q;
    assign bus.rd_o        = rd_q;
    assign bus.result_o    = result_q;
    assign bus.mem_req_o   = req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.rsv_set_o   = set_q;
    assign bus.rsv_clr_o   = clr_q;
    assign bus.rsv_addr_o  = rsv_addr_q;

endmodule

// File: tb/tb_amo_unit.sv
// Directed bench for amo_unit: memory responder with programmable ready delay plus a reservation register.
module tb_amo_unit;
    import amo_pkg::*;

    logic clk;
    logic rst;

    amo_if ifc ();

    amo_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // responder state
    int          ready_delay   = 0;
    bit          hold_rvalid   = 1'b0;
    bit          inject_rvalid = 1'b0;
    logic [31:0] mem_word      = 32'h0;
    int          rd_cnt        = 0;
    int          wr_cnt        = 0;
    int          stable_err    = 0;
    int          waited        = 0;
    bit          rd_acc        = 1'b0;
    logic [31:0] wr_addr       = 32'h0;
    logic [31:0] wr_data       = 32'h0;
    logic [31:0] snap_addr     = 32'h0;
    logic [31:0] snap_wdata    = 32'h0;
    logic        snap_we       = 1'b0;

    always @(negedge clk) begin
        ifc.mem_ready_i  = 1'b0;
        ifc.mem_rvalid_i = 1'b0;
        if (!rst) begin
            rd_acc          = 1'b0;
            waited          = 0;
            ifc.mem_rdata_i = 32'h0;
            ifc.rsv_valid_i = 1'b0;
            ifc.rsv_addr_i  = 32'h0;
        end else begin
            if (inject_rvalid) begin
                ifc.mem_rvalid_i = 1'b1;
                ifc.mem_rdata_i  = 32'hBAD0BAD0;
            end
            if (rd_acc && !hold_rvalid) begin
                ifc.mem_rvalid_i = 1'b1;
                ifc.mem_rdata_i  = mem_word;
            end
            rd_acc = 1'b0;
            if (ifc.mem_req_o) begin
                if (waited == 0) begin
                    snap_addr  = ifc.mem_addr_o;
                    snap_wdata = ifc.mem_wdata_o;
                    snap_we    = ifc.mem_we_o;
                end else if (snap_addr !== ifc.mem_addr_o || snap_wdata !== ifc.mem_wdata_o ||
                             snap_we !== ifc.mem_we_o) begin
                    stable_err++;
                end
                if (waited < ready_delay) begin
                    waited++;
                end else begin
                    ifc.mem_ready_i = 1'b1;
                    waited = 0;
                    if (ifc.mem_we_o) begin
                        wr_cnt++;
                        wr_addr = ifc.mem_addr_o;
                        wr_data = ifc.mem_wdata_o;
                    end else begin
                        rd_cnt++;
                        rd_acc = 1'b1;
                    end
                end
            end
            if (ifc.rsv_set_o) begin
                ifc.rsv_valid_i = 1'b1;
                ifc.rsv_addr_i  = ifc.rsv_addr_o;
            end
            if (ifc.rsv_clr_o) ifc.rsv_valid_i = 1'b0;
        end
    end

    // observations of the most recent operation
    int          lat;
    bit          got_done;
    logic        o_err, o_rdwe, o_set, o_clr, idle_busy, idle_done;
    logic [31:0] o_res, o_rsvaddr;
    logic [4:0]  o_rd;

    function automatic logic [31:0] ctl_bits();
        return {24'd0, ifc.busy_o, ifc.done_o, ifc.err_o, ifc.rd_we_o,
                ifc.mem_req_o, ifc.mem_we_o, ifc.rsv_set_o, ifc.rsv_clr_o};
    endfunction

    task automatic do_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r, input bit poke);
        ifc.start_i  = 1'b1;
        ifc.funct5_i = f5;
        ifc.addr_i   = a;
        ifc.rs2_i    = d;
        ifc.rd_i     = r;
        lat      = 0;
        got_done = 1'b0;
        while (!got_done && lat < 40) begin
            @(negedge clk);
            ifc.start_i = 1'b0;
            lat++;
            if (poke && lat == 2) begin
                ifc.start_i  = 1'b1;
                ifc.funct5_i = F5_LR;
                ifc.addr_i   = 32'h7F0;
            end
            if (ifc.done_o) begin
                got_done  = 1'b1;
                o_err     = ifc.err_o;
                o_rdwe    = ifc.rd_we_o;
                o_res     = ifc.result_o;
                o_rd      = ifc.rd_o;
                o_set     = ifc.rsv_set_o;
                o_clr     = ifc.rsv_clr_o;
                o_rsvaddr = ifc.rsv_addr_o;
            end
        end
        ifc.start_i = 1'b0;
        @(negedge clk);
        idle_busy = ifc.busy_o;
        idle_done = ifc.done_o;
    endtask

    task automatic expect_op(input string tag, input int exp_lat, input logic exp_err,
                             input logic exp_rdwe, input logic exp_set, input logic exp_clr);
        check_eq({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_err"}, 32'(o_err), 32'(exp_err));
        check_eq({tag, "_rd_we"}, 32'(o_rdwe), 32'(exp_rdwe));
        check_eq({tag, "_rsv_set"}, 32'(o_set), 32'(exp_set));
        check_eq({tag, "_rsv_clr"}, 32'(o_clr), 32'(exp_clr));
        check_eq({tag, "_idle_after"}, 32'({idle_busy, idle_done}), 32'd0);
    endtask

    typedef struct packed {
        logic [4:0]  f5;
        logic [31:0] old_v;
        logic [31:0] rs2_v;
        logic [31:0] new_v;
    } amo_vec_t;

    amo_vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        vecs = '{
            '{F5_ADD,  32'hFFFFFFFF, 32'h00000002, 32'h00000001},
            '{F5_MIN,  32'h80000000, 32'h00000001, 32'h80000000},
            '{F5_MINU, 32'h80000000, 32'h00000001, 32'h00000001},
            '{F5_MAX,  32'h80000000, 32'h00000001, 32'h00000001},
            '{F5_MAXU, 32'h80000000, 32'h00000001, 32'h80000000},
            '{F5_MAX,  32'h00000007, 32'h00000007, 32'h00000007},
            '{F5_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
            '{F5_OR,   32'h0000F000, 32'h0000000F, 32'h0000F00F},
            '{F5_AND,  32'h12345678, 32'h0F0F0F0F, 32'h02040608},
            '{F5_SWAP, 32'h11111111, 32'h22222222, 32'h22222222}
        };
        rst          = 1'b0;
        ifc.start_i  = 1'b0;
        ifc.funct5_i = 5'd0;
        ifc.addr_i   = 32'h0;
        ifc.rs2_i    = 32'h0;
        ifc.rd_i     = 5'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctl", ctl_bits(), 32'h0);
        check_eq("reset_result", ifc.result_o, 32'h0);
        check_eq("reset_mem_addr", ifc.mem_addr_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // LR then SC hit, then SC miss
        mem_word = 32'hDEADBEEF;
        rd0 = rd_cnt;
        do_op(F5_LR, 32'h100, 32'h0, 5'd5, 1'b0);
        expect_op("lr", 3, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("lr_result", o_res, 32'hDEADBEEF);
        check_eq("lr_rd", 32'(o_rd), 32'd5);
        check_eq("lr_rsv_addr", o_rsvaddr, 32'h100);
        check_eq("lr_reads", rd_cnt - rd0, 1);

        wr0 = wr_cnt;
        do_op(F5_SC, 32'h100, 32'h55, 5'd6, 1'b0);
        expect_op("sc_hit", 2, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("sc_hit_result", o_res, 32'h0);
        check_eq("sc_hit_wr_addr", wr_addr, 32'h100);
        check_eq("sc_hit_wr_data", wr_data, 32'h55);
        check_eq("sc_hit_writes", wr_cnt - wr0, 1);

        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_op(F5_SC, 32'h100, 32'h66, 5'd6, 1'b0);
        expect_op("sc_miss", 1, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("sc_miss_result", o_res, 32'h1);
        check_eq("sc_miss_no_mem", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // AMO ALU table
        for (int i = 0; i < 10; i++) begin
            mem_word = vecs[i].old_v;
            do_op(vecs[i].f5, 32'h200, vecs[i].rs2_v, 5'd7, 1'b0);
            expect_op($sformatf("amo%0d", i), 4, 1'b0, 1'b1, 1'b0, 1'b0);
            check_eq($sformatf("amo%0d_result", i), o_res, vecs[i].old_v);
            check_eq($sformatf("amo%0d_wdata", i), wr_data, vecs[i].new_v);
            check_eq($sformatf("amo%0d_waddr", i), wr_addr, 32'h200);
        end

        // Backpressure on both phases, with a start pulse while busy
        ready_delay = 3;
        mem_word    = 32'h00001234;
        stable_err  = 0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_op(F5_SWAP, 32'h204, 32'h0000ABCD, 5'd9, 1'b1);
        expect_op("bp", 10, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("bp_result", o_res, 32'h1234);
        check_eq("bp_wdata", wr_data, 32'hABCD);
        check_eq("bp_stable", stable_err, 0);
        repeat (3) @(negedge clk);
        check_eq("busy_start_ignored", (rd_cnt - rd0) * 16 + (wr_cnt - wr0), 32'h11);
        check_eq("busy_start_no_done", ctl_bits(), 32'h0);
        ready_delay = 0;

        // Misaligned and illegal opcodes
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_op(F5_LR, 32'h102, 32'h0, 5'd8, 1'b0);
        expect_op("misaligned", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(5'b11111, 32'h100, 32'h0, 5'd8, 1'b0);
        expect_op("illegal", 1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("err_no_mem", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // rd=0 suppresses writeback; matching AMO kills reservation, non-matching does not
        mem_word = 32'hCAFEF00D;
        do_op(F5_LR, 32'h300, 32'h0, 5'd0, 1'b0);
        expect_op("lr_rd0", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("lr_rd0_result", o_res, 32'hCAFEF00D);
        mem_word = 32'h10;
        do_op(F5_OR, 32'h300, 32'h1, 5'd4, 1'b0);
        expect_op("amo_match", 4, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("amo_match_wdata", wr_data, 32'h11);
        do_op(F5_SC, 32'h300, 32'h5, 5'd4, 1'b0);
        check_eq("sc_after_amo_result", o_res, 32'h1);
        mem_word = 32'h44;
        do_op(F5_LR, 32'h400, 32'h0, 5'd3, 1'b0);
        do_op(F5_ADD, 32'h404, 32'h1, 5'd3, 1'b0);
        expect_op("amo_other", 4, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("amo_other_wdata", wr_data, 32'h45);
        do_op(F5_SC, 32'h400, 32'h99, 5'd3, 1'b0);
        check_eq("sc_keep_result", o_res, 32'h0);
        check_eq("sc_keep_wdata", wr_data, 32'h99);

        // Reset while waiting for read data
        hold_rvalid  = 1'b1;
        mem_word     = 32'h600D600D;
        ifc.funct5_i = F5_LR;
        ifc.addr_i   = 32'h500;
        ifc.rd_i     = 5'd9;
        ifc.start_i  = 1'b1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        @(negedge clk);
        check_eq("rdwait_ctl", ctl_bits(), 32'h80);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst_ctl", ctl_bits(), 32'h0);
        check_eq("midrst_result", ifc.result_o, 32'h0);
        check_eq("midrst_addr", ifc.mem_addr_o, 32'h0);
        check_eq("midrst_rsv_addr", ifc.rsv_addr_o, 32'h0);
        check_eq("midrst_rd", 32'(ifc.rd_o), 32'h0);
        @(negedge clk);
        rst           = 1'b1;
        hold_rvalid   = 1'b0;
        inject_rvalid = 1'b1;
        @(negedge clk);
        check_eq("late_rvalid_1", ctl_bits(), 32'h0);
        @(negedge clk);
        inject_rvalid = 1'b0;
        check_eq("late_rvalid_2", ctl_bits(), 32'h0);
        repeat (2) @(negedge clk);
        do_op(F5_LR, 32'h500, 32'h0, 5'd9, 1'b0);
        expect_op("lr_after_rst", 3, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("lr_after_rst_result", o_res, 32'h600D600D);
        check_eq("lr_after_rst_rsv_addr", o_rsvaddr, 32'h500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
